apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

APB completer (slave) for the team's four-slave APB fabric. It responds to one PSELx line from the APB master and holds a small word-addressed register file. Wait states are programmable, and out-of-window or illegal accesses get a PSLVERR response. One instance sits behind each of PSEL1..PSEL4, with BASE_ADDR set to that slave's address window.

## Interface
- BASE_ADDR, 32'd1: first PADDR value decoded by this slave (word address).
- DEPTH, 10: number of 32-bit words; valid offsets are 0..DEPTH-1, and DEPTH must be ≤ 256.
- WAIT_CYCLES, 0: wait states inserted before PREADY in each access phase; range 0..15.
- ID_VALUE, 32'hA5B0_0000: read-only contents of offset 0.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  reset; synchronous, active-high (PRESETn=1 resets).
- PSEL  in  1  select from the master (PSELx).
- PENABLE  in  1  access-phase marker.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  32  word address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data (registered).
- PREADY  out  1  transfer-complete, decoded from state registers only.
- PSLVERR  out  1  error response; valid only while PREADY=1.

## Operation
- offset = PADDR − BASE_ADDR, as 32-bit unsigned with wrap. An access is out of window when offset ≥ DEPTH, which also covers PADDR < BASE_ADDR.
- Error = out of window, or a write to offset 0.
- mem[1..DEPTH-1] is read/write. Offset 0 always reads ID_VALUE.
- FSM has two states, IDLE and ACCESS.
  - IDLE: a setup phase is sampled (PSEL=1, PENABLE=0). The block captures offset, PWRITE, PWDATA and the error flag, then loads cnt=WAIT_CYCLES.
    - On a read, PRDATA ← mem[offset], ID_VALUE for offset 0, or 0 on error.
    - On a write, PRDATA is unchanged.
    - State → ACCESS.
  - ACCESS with cnt>0: cnt decrements on each edge.
  - ACCESS with cnt=0: PREADY=1, and PSLVERR equals the captured error flag.
  - Completion is an edge in ACCESS with cnt=0 and PSEL=PENABLE=1.
    - A write with no error commits mem[offset] ← captured PWDATA.
    - An errored write leaves memory unchanged.
    - State → IDLE.
  - If PSEL=0 is sampled in ACCESS (master abort), the block goes to IDLE with no write.
  - PENABLE=0 with PSEL=1 in ACCESS is treated as an abort followed by a new setup: the block recaptures and stays in ACCESS.
- The block ignores PADDR, PWRITE and PWDATA changes during ACCESS, because the captured values are the ones used.

## Timing
- Reset values: state IDLE, cnt=0, PRDATA=0, PREADY=0, PSLVERR=0, mem[1..DEPTH-1]=0.
- Reset wins over any in-flight access, and a write in progress is discarded.
- Setup phase at cycle T, first access cycle at T+1, PREADY high in cycle T+1+WAIT_CYCLES.
- Total transfer is 2+WAIT_CYCLES cycles.
- PRDATA is stable from T+1 until the next captured read.
- Back-to-back transfers work as follows. The completion edge returns the FSM to IDLE. The master's next setup cycle is sampled at the following edge, so there is no dead cycle beyond APB's mandatory setup.
- A write followed immediately by a read of the same offset returns the new data, because the write commits at the completion edge, before the next setup edge.
- PREADY=0 and PSLVERR=0 in IDLE and throughout every wait state.

## Configuration
- APB_SLAVE_WAIT_EN defined: the cnt register and wait-state logic are compiled in and behave as above.
- APB_SLAVE_WAIT_EN undefined: no counter, and WAIT_CYCLES is ignored. PREADY=1 in every ACCESS cycle, so every transfer is exactly 2 cycles.

## Test plan
Parameters: BASE_ADDR=11, DEPTH=10, WAIT_CYCLES=2, ID_VALUE=32'hA5B0_0002, with APB_SLAVE_WAIT_EN defined unless noted.

1. Write 32'hDEAD_BEEF to PADDR=15, then read PADDR=15 → PREADY high 3 cycles after each setup, PSLVERR=0, PRDATA=32'hDEAD_BEEF.
2. Read PADDR=11 → PRDATA=32'hA5B0_0002. Then write 32'h1234 to PADDR=11 → PSLVERR=1 with PREADY, and a reread still gives 32'hA5B0_0002.
3. Read PADDR=21 and PADDR=5 (out of window) → PSLVERR=1, PRDATA=0. Write to PADDR=21 → PSLVERR=1 and no mem[] change.
4. Write 32'h55 to PADDR=20, with PRESETn=1 asserted during the second wait cycle → outputs 0, state IDLE, and a subsequent read of PADDR=20 returns 0.
5. Back-to-back writes of 1, 2, 3 to PADDR=12, 13, 14, then reads of all three → 1, 2, 3, each transfer 4 cycles, no extra idle between transfers.
6. With APB_SLAVE_WAIT_EN undefined, repeat scenario 1 → PREADY high in the first access cycle, each transfer 2 cycles.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB completer with a small word-addressed register file; offset 0 is a read-only ID word.
// Optional wait-state counter is compiled in when APB_SLAVE_WAIT_EN is defined.
module apb_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'd1,
  parameter int          DEPTH       = 10,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e          state_q, state_d;
  logic [31:0]     offset;
  logic            oow, err, capture, ready_st, complete;
  logic [AW-1:0]   off_q;
  logic            wr_q, err_q;
  logic [31:0]     wdata_q, prdata_q;
  logic [31:0]     mem_q [DEPTH];

  // Unsigned wrap makes PADDR < BASE_ADDR land far above DEPTH.
  assign offset   = PADDR - BASE_ADDR;
  assign oow      = (offset >= 32'(DEPTH));
  assign err      = oow | (PWRITE & (offset == 32'd0));
  assign capture  = PSEL & ~PENABLE;

`ifdef APB_SLAVE_WAIT_EN
  logic [3:0] cnt_q;

  always_ff @(posedge PCLK) begin
    if (PRESETn)                               cnt_q <= 4'd0;
    else if (capture)                          cnt_q <= 4'(WAIT_CYCLES);
    else if (state_q == ACCESS && cnt_q != 0)  cnt_q <= cnt_q - 4'd1;
  end

  assign ready_st = (state_q == ACCESS) && (cnt_q == 4'd0);
`else
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);
  assign ready_st    = (state_q == ACCESS);
`endif

  assign complete = ready_st & PSEL & PENABLE;

  always_ff @(posedge PCLK) begin
    if (PRESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = ACCESS;
      ACCESS: begin
        if (!PSEL)         state_d = IDLE;
        else if (!PENABLE) state_d = ACCESS;  // abort + new setup, recaptured below
        else if (ready_st) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PREADY  = ready_st;
    PSLVERR = ready_st & err_q;
  end

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      off_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= 32'd0;
      prdata_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      if (capture) begin
        off_q   <= offset[AW-1:0];
        wr_q    <= PWRITE;
        wdata_q <= PWDATA;
        err_q   <= err;
        if (!PWRITE) begin
          if (err)                 prdata_q <= 32'd0;
          else if (offset == 32'd0) prdata_q <= ID_VALUE;
          else                     prdata_q <= mem_q[offset[AW-1:0]];
        end
      end
      if (complete && wr_q && !err_q) mem_q[off_q] <= wdata_q;
    end
  end

  assign PRDATA = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem; expected wait count follows APB_SLAVE_WAIT_EN.
module tb_apb_slave_mem;
  localparam logic [31:0] BASE = 32'd11;
  localparam int          DEP  = 10;
  localparam int          WAIT = 2;
  localparam logic [31:0] ID   = 32'hA5B0_0002;
`ifdef APB_SLAVE_WAIT_EN
  localparam int EW = WAIT;
`else
  localparam int EW = 0;
`endif
  localparam int XFER = 2 + EW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  int          total = 0, bad = 0, cyc = 0;

  apb_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEP), .WAIT_CYCLES(WAIT), .ID_VALUE(ID)) dut (
    .PCLK(clk), .PRESETn(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One full transfer; bus is scrambled during ACCESS since captured values must be used.
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     output logic [31:0] rdata, output logic err, output int ncyc,
                     output bit wait_bad, output int done_at);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
    ncyc = 1; wait_bad = 0;
    @(posedge clk); #1;
    penable = 1; ncyc = 2;
    paddr = 32'hFFFF_FFFF; pwdata = ~data; pwrite = ~wr;
    while (!pready && ncyc < 20) begin
      if (pslverr) wait_bad = 1;
      @(posedge clk); #1;
      ncyc++;
    end
    if (!pready) ncyc = 99;
    rdata = prdata; err = pslverr; done_at = cyc;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (pready !== 1'b0) begin bad++; $display("FAIL reset_pready got=%b exp=0", pready); end
    total++; if (pslverr !== 1'b0) begin bad++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
    total++; if (prdata !== 32'd0) begin bad++; $display("FAIL reset_prdata got=%h exp=0", prdata); end
    rst = 0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e; int n, t; bit wb;
    apb(1, 32'd15, 32'hDEAD_BEEF, rd, e, n, wb, t);
    total++; if (n !== XFER || wb) begin bad++; $display("FAIL wr15_timing got=%0d wait_err=%0b exp=%0d", n, wb, XFER); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr15_err got=%b exp=0", e); end
    apb(0, 32'd15, 32'd0, rd, e, n, wb, t);
    total++; if (n !== XFER || wb) begin bad++; $display("FAIL rd15_timing got=%0d wait_err=%0b exp=%0d", n, wb, XFER); end
    total++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin bad++; $display("FAIL rd15_data got=%h err=%b exp=deadbeef err=0", rd, e); end
    idle();
  endtask

  task automatic test_id();
    logic [31:0] rd; logic e; int n, t; bit wb;
    apb(0, 32'd11, 32'd0, rd, e, n, wb, t);
    total++; if (rd !== ID || e !== 1'b0) begin bad++; $display("FAIL id_read got=%h err=%b exp=%h err=0", rd, e, ID); end
    apb(1, 32'd11, 32'h1234, rd, e, n, wb, t);
    total++; if (e !== 1'b1 || n !== XFER) begin bad++; $display("FAIL id_write_err got=%b cyc=%0d exp=1 cyc=%0d", e, n, XFER); end
    total++; if (rd !== ID) begin bad++; $display("FAIL write_keeps_prdata got=%h exp=%h", rd, ID); end
    apb(0, 32'd11, 32'd0, rd, e, n, wb, t);
    total++; if (rd !== ID || e !== 1'b0) begin bad++; $display("FAIL id_reread got=%h err=%b exp=%h err=0", rd, e, ID); end
    idle();
  endtask

  task automatic test_oow();
    logic [31:0] rd; logic e; int n, t; bit wb;
    apb(0, 32'd21, 32'd0, rd, e, n, wb, t);
    total++; if (rd !== 32'd0 || e !== 1'b1 || wb) begin bad++; $display("FAIL rd21 got=%h err=%b wait_err=%0b exp=0 err=1", rd, e, wb); end
    apb(0, 32'd5, 32'd0, rd, e, n, wb, t);
    total++; if (rd !== 32'd0 || e !== 1'b1) begin bad++; $display("FAIL rd5 got=%h err=%b exp=0 err=1", rd, e); end
    apb(1, 32'd21, 32'hCAFE_F00D, rd, e, n, wb, t);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL wr21_err got=%b exp=1", e); end
    apb(0, 32'd15, 32'd0, rd, e, n, wb, t);
    total++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin bad++; $display("FAIL oow_nochange got=%h err=%b exp=deadbeef", rd, e); end
    apb(0, 32'd20, 32'd0, rd, e, n, wb, t);
    total++; if (rd !== 32'd0 || e !== 1'b0) begin bad++; $display("FAIL last_word got=%h err=%b exp=0 err=0", rd, e); end
    idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic e; int n, t; bit wb;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'd16; pwdata = 32'h77;
    @(posedge clk); #1;
    psel = 0;
    @(posedge clk); #1;
    total++; if (pready !== 1'b0) begin bad++; $display("FAIL abort_idle pready=%b exp=0", pready); end
    apb(0, 32'd16, 32'd0, rd, e, n, wb, t);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL abort_nowrite got=%h exp=0", rd); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int n, t, prev; bit wb;
    logic [31:0] rds [3];
    for (int i = 0; i < 6; i++) begin
      if (i < 3) apb(1, 32'(12 + i), 32'(i + 1), rd, e, n, wb, t);
      else       apb(0, 32'(9 + i), 32'd0, rd, e, n, wb, t);
      if (i >= 3) rds[i-3] = rd;
      total++; if (n !== XFER || e !== 1'b0) begin bad++; $display("FAIL b2b_xfer%0d got=%0d err=%b exp=%0d", i, n, e, XFER); end
      if (i > 0) begin
        total++; if (t - prev !== XFER) begin bad++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, t - prev, XFER); end
      end
      prev = t;
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (rds[i] !== 32'(i + 1)) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%0d", i, rds[i], i + 1); end
    end
    idle();
  endtask

  task automatic test_reset_midwrite();
    logic [31:0] rd; logic e; int n, t, k; bit wb;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'd20; pwdata = 32'h55;
    @(posedge clk); #1;
    penable = 1; k = 1;
    while (k < ((EW >= 2) ? 2 : 1)) begin @(posedge clk); #1; k++; end
    rst = 1;
    @(posedge clk); #1;
    total++; if (pready !== 1'b0 || pslverr !== 1'b0) begin bad++; $display("FAIL rst_mid_ctl pready=%b pslverr=%b exp=0", pready, pslverr); end
    total++; if (prdata !== 32'd0) begin bad++; $display("FAIL rst_mid_prdata got=%h exp=0", prdata); end
    rst = 0; psel = 0; penable = 0;
    apb(0, 32'd20, 32'd0, rd, e, n, wb, t);
    total++; if (rd !== 32'd0 || n !== XFER) begin bad++; $display("FAIL rst_mid_discard got=%h cyc=%0d exp=0 cyc=%0d", rd, n, XFER); end
    apb(0, 32'd15, 32'd0, rd, e, n, wb, t);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_mem_clear got=%h exp=0", rd); end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_id();
    test_oow();
    test_abort();
    test_back_to_back();
    test_reset_midwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
